// File: rtl/dma_axis_downsizer.sv
// Purpose: split each wide MM2S beat into LANES narrow samples (lane 0 first), keep tlast, check line length, count lines.
// Latency: first sample valid 1 cycle after the input handshake; sustained 1 sample/cycle with no bubble between beats.
// Backpressure: m_axis_tready low freezes the output; s_axis_tready only rises when empty or the last lane is leaving.
module dma_axis_downsizer #(
    parameter int DATA_W_IN = 64,
    parameter int LANE_W    = 16,
    parameter int LEN_W     = 16
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_aresetn,
    input  logic [DATA_W_IN-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [LANE_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    input  logic [LEN_W-1:0]     cfg_line_len,
    input  logic                 err_clr,
    output logic                 len_err,
    output logic [LEN_W-1:0]     line_cnt
);
    localparam int LANES  = DATA_W_IN / LANE_W;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [DATA_W_IN-1:0]          r_hold_dat;
    logic                          r_hold_last;
    logic [LIDX_W-1:0]             r_lane_idx;
    logic [LIDX_W-1:0]             w_lane_nxt;
    logic                          w_load;
    logic [LEN_W-1:0]              r_sample_cnt;
    logic [LEN_W-1:0]              r_line_cnt;
    logic                          r_len_err;
    logic                          w_last_lane;
    logic                          w_out_hs;
    logic                          w_in_hs;
    logic [LEN_W-1:0]              w_n;
    logic                          w_len_match;
    logic [LANES-1:0][LANE_W-1:0]  w_lanes;

    // Lane view of the holding register and the stream-side outputs.
    assign w_lanes       = r_hold_dat;
    assign w_last_lane   = (r_lane_idx == LAST_LANE);
    assign m_axis_tdata  = w_lanes[r_lane_idx];
    assign m_axis_tvalid = (r_state == S_FULL);
    assign m_axis_tlast  = r_hold_last && w_last_lane;
    // Accept a new beat while empty, or in the same cycle the last lane drains.
    assign s_axis_tready = (r_state == S_EMPTY) || (m_axis_tready && w_last_lane);
    assign w_out_hs      = m_axis_tvalid && m_axis_tready;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_n           = r_sample_cnt + 1'b1;
    assign w_len_match   = (w_n == cfg_line_len);
    assign len_err       = r_len_err;
    assign line_cnt      = r_line_cnt;

    // Next-state logic: load on accept, step through lanes on each output handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane_idx;
        w_load      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (s_axis_tvalid) begin
                    w_load      = 1'b1;
                    w_lane_nxt  = '0;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_out_hs) begin
                    if (!w_last_lane) begin
                        w_lane_nxt = r_lane_idx + 1'b1;
                    end else if (w_in_hs) begin
                        w_load     = 1'b1;
                        w_lane_nxt = '0;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // State, lane index and holding register.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state     <= S_EMPTY;
            r_lane_idx  <= '0;
            r_hold_dat  <= '0;
            r_hold_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_idx <= w_lane_nxt;
            if (w_load) begin
                r_hold_dat  <= s_axis_tdata;
                r_hold_last <= s_axis_tlast;
            end
        end
    end

    // Line-length check: tlast and the configured length must coincide; either alone is an error.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_sample_cnt <= '0;
            r_line_cnt   <= '0;
            r_len_err    <= 1'b0;
        end else begin
            if (w_out_hs) begin
                if (m_axis_tlast || w_len_match) begin
                    r_sample_cnt <= '0;
                end else begin
                    r_sample_cnt <= w_n;
                end
                if (m_axis_tlast) begin
                    r_line_cnt <= r_line_cnt + 1'b1;
                end
            end
            // Clear wins over a same-cycle error.
            if (err_clr) begin
                r_len_err <= 1'b0;
            end else if (w_out_hs && (m_axis_tlast != w_len_match)) begin
                r_len_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/dma_axis_downsizer.md
Name: dma_axis_downsizer

Overview:
- Sits directly downstream of the DMA MM2S stream output (m_mm2s_axis_*).
- Splits each wide MM2S beat into LANES narrow sample beats, least-significant lane first.
- Feeds the sample-oriented processing core and preserves line boundaries (tlast).
- Checks each received line against a configured line length and counts completed lines for software status.

Parameters:
- DATA_W_IN, 64, width of the input stream (matches the DMA stream width).
- LANE_W, 16, width of one output sample. DATA_W_IN must be an integer multiple of LANE_W; LANES = DATA_W_IN/LANE_W.
- LEN_W, 16, width of the sample counter, cfg_line_len and line_cnt.

Ports:
- m_axi_aclk  in  1  sole clock; everything is rising-edge.
- m_axi_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_W_IN  wide beat from DMA MM2S.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last beat of the line.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  LANE_W  sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last sample of the line.
- m_axis_tready  in  1  output ready.
- cfg_line_len  in  LEN_W  expected samples per line. Must be ≥1; software holds it stable while the block is busy.
- err_clr  in  1  single-cycle pulse that clears len_err.
- len_err  out  1  sticky line-length mismatch flag.
- line_cnt  out  LEN_W  number of lines emitted; wraps modulo 2^LEN_W.

Behaviour:
- Reset values: all outputs 0, except s_axis_tready = 1 (the holding register is empty). Internal state: hold register empty, lane_idx = 0, sample_cnt = 0.
- Datapath:
  - One holding register stores {tdata, tlast} plus lane_idx (range 0..LANES-1).
  - m_axis_tdata = hold[lane_idx*LANE_W +: LANE_W].
  - m_axis_tvalid = hold_full.
  - m_axis_tlast = hold_tlast && (lane_idx == LANES-1).
- Input acceptance: s_axis_tready = !hold_full || (m_axis_tready && lane_idx == LANES-1). This combinational path lets back-to-back beats stream at 1 sample/cycle with no bubble.
- State machine, two states:
  - EMPTY: on s_axis_tvalid, load the hold register, set lane_idx = 0 and go to FULL.
  - FULL: on each output handshake with lane_idx < LANES-1, increment lane_idx.
  - FULL, on the handshake of lane LANES-1: if the input handshakes in the same cycle, reload the hold register, set lane_idx = 0 and stay FULL; otherwise go to EMPTY.
- Latency: the first sample is valid 1 cycle after the input handshake. Sustained throughput is 1 sample/cycle, i.e. one input beat per LANES cycles.
- Output stall: while m_axis_tready = 0, tdata, tvalid and tlast hold stable and lane_idx does not advance.
- Line check, evaluated on every output handshake (n = sample_cnt + 1):
  - Output tlast and n == cfg_line_len: line OK. Set sample_cnt = 0, line_cnt += 1.
  - Output tlast and n != cfg_line_len: set len_err. Set sample_cnt = 0, line_cnt += 1.
  - No tlast and n == cfg_line_len: set len_err. Set sample_cnt = 0; this restarts the count and line_cnt is unchanged.
  - Otherwise: sample_cnt = n.
- err_clr has priority over a same-cycle error set: len_err reads 0 in the following cycle.
- len_err and line_cnt are registered and update in the cycle after the handshake that causes them.
- line_cnt wraps from 2^LEN_W-1 to 0 with no flag.
- Reset mid-operation: the hold contents are discarded and all counters cleared asynchronously. After release, the next accepted beat is treated as the start of a line.

Test Plan:
- Single beat, lanes 0x4444_3333_2222_1111, tlast=1, cfg_line_len=4, m_axis_tready=1 → samples 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; tlast only on 0x4444; line_cnt=1; len_err=0.
- 16 beats of incrementing data with tlast on beat 15, cfg_line_len=64, tready held high → exactly 64 samples at 1/cycle with no bubbles; s_axis_tready is high once every 4 cycles; tlast on sample 63; len_err=0.
- Same stream with m_axis_tready toggling on a 3-cycle-on / 2-cycle-off pattern → output sequence identical to the previous scenario; the output holds stable during stalls; no sample lost or duplicated.
- cfg_line_len=8, input tlast on beat 0 → len_err=1 after sample 3 (short line). Then pulse err_clr → len_err=0. Then a 2-beat line with no tlast → len_err=1 after sample 7 (long line); line_cnt unchanged.
- Assert reset after 2 samples of a beat, then deassert and send a fresh 1-beat line with cfg_line_len=4 → outputs cleared during reset; the new line emits 4 samples; len_err=0; line_cnt=1.
- Loopback through the DMA: MM2S from address 0, 16 beats → 64 samples with the correct lane order; line_cnt=1.
